// File: rtl/pixel_shift_sequencer_if.sv
// Handshake and write-port bundle for pixel_shift_sequencer.
//   start, abort       : frame control from the host
//   sensor_valid/ready : sample handshake with the sensor stream
//   out_we/out_x/out_y : write strobe and coordinate into the 1920x1080 luminance store
//   phase              : current half-pixel shift (bit0 horizontal, bit1 vertical)
//   line_start         : marks the write of the first sample of each sensor line
//   busy, frame_done   : sequencer status
// master = host/sensor/store side, slave = sequencer side.
interface pixel_shift_sequencer_if;
  logic        start;
  logic        abort;
  logic        sensor_valid;
  logic        sensor_ready;
  logic        out_we;
  logic [10:0] out_x;
  logic [10:0] out_y;
  logic [1:0]  phase;
  logic        line_start;
  logic        busy;
  logic        frame_done;

  modport master (
    output start, abort, sensor_valid,
    input  sensor_ready, out_we, out_x, out_y, phase, line_start, busy, frame_done
  );

  modport slave (
    input  start, abort, sensor_valid,
    output sensor_ready, out_we, out_x, out_y, phase, line_start, busy, frame_done
  );
endinterface

// File: rtl/pixel_shift_sequencer.sv
// Four-phase pixel-shift sequencer: builds a 2x-resolution luminance frame from four
// half-pixel-shifted sensor passes. Each accepted sensor sample (sx, sy) of phase p is
// written one cycle later to (2*sx + p[0], 2*sy + p[1]).
// Ports:
//   clk : sole clock, rising edge
//   rst : synchronous active-low reset
//   sif : pixel_shift_sequencer_if.slave (start/abort, sensor handshake, store writes, status)
module pixel_shift_sequencer #(
  parameter int unsigned SENSOR_WIDTH  = 960,
  parameter int unsigned SENSOR_HEIGHT = 540,
  parameter int unsigned HBLANK        = 16
) (
  input logic                    clk,
  input logic                    rst,
  pixel_shift_sequencer_if.slave sif
);

  typedef enum logic [1:0] {StIdle, StActive, StHblank, StDone} state_e;

  localparam logic [10:0] XLast     = 11'(SENSOR_WIDTH - 1);
  localparam logic [10:0] YLast     = 11'(SENSOR_HEIGHT - 1);
  localparam logic [7:0]  BlankLast = 8'(HBLANK - 1);

  state_e      state_q, state_d;
  logic [10:0] sx_q, sx_d;
  logic [10:0] sy_q, sy_d;
  logic [1:0]  phase_q, phase_d;
  logic [7:0]  blank_q, blank_d;
  logic [10:0] out_x_q, out_x_d;
  logic [10:0] out_y_q, out_y_d;
  logic        out_we_q, out_we_d;
  logic        line_start_q, line_start_d;
  logic        ready_q, busy_q, done_q;
  logic        accept;

  // ready_q is kept equal to (state_q == StActive), so it alone qualifies the handshake.
  assign accept = ready_q & sif.sensor_valid;

  always_comb begin
    state_d      = state_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    phase_d      = phase_q;
    blank_d      = blank_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    out_we_d     = 1'b0;
    line_start_d = 1'b0;

    // Abort wins over everything, including a same-cycle start or acceptance.
    if (sif.abort) begin
      state_d = StIdle;
      sx_d    = '0;
      sy_d    = '0;
      phase_d = '0;
      blank_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (sif.start) begin
            state_d = StActive;
            sx_d    = '0;
            sy_d    = '0;
            phase_d = '0;
          end
        end
        StActive: begin
          if (accept) begin
            out_we_d     = 1'b1;
            line_start_d = (sx_q == '0);
            out_x_d      = {sx_q[9:0], phase_q[0]};
            out_y_d      = {sy_q[9:0], phase_q[1]};
            if (sx_q == XLast) begin
              sx_d    = '0;
              blank_d = '0;
              state_d = StHblank;
            end else begin
              sx_d = sx_q + 11'd1;
            end
          end
        end
        StHblank: begin
          if (blank_q == BlankLast) begin
            blank_d = '0;
            if (sy_q != YLast) begin
              sy_d    = sy_q + 11'd1;
              state_d = StActive;
            end else if (phase_q != 2'd3) begin
              sy_d    = '0;
              phase_d = phase_q + 2'd1;
              state_d = StActive;
            end else begin
              state_d = StDone;
            end
          end else begin
            blank_d = blank_q + 8'd1;
          end
        end
        StDone: begin
          state_d = StIdle;
          sy_d    = '0;
          phase_d = '0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      sx_q         <= '0;
      sy_q         <= '0;
      phase_q      <= '0;
      blank_q      <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_we_q     <= 1'b0;
      line_start_q <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      phase_q      <= phase_d;
      blank_q      <= blank_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      out_we_q     <= out_we_d;
      line_start_q <= line_start_d;
      ready_q      <= (state_d == StActive);
      busy_q       <= (state_d != StIdle);
      done_q       <= (state_d == StDone);
    end
  end

  assign sif.sensor_ready = ready_q;
  assign sif.out_we       = out_we_q;
  assign sif.out_x        = out_x_q;
  assign sif.out_y        = out_y_q;
  assign sif.phase        = phase_q;
  assign sif.line_start   = line_start_q;
  assign sif.busy         = busy_q;
  assign sif.frame_done   = done_q;

endmodule

// File: tb/tb_pixel_shift_sequencer.sv
// Self-checking bench for pixel_shift_sequencer (4x2 sensor, HBLANK=2).
// A reference model enumerates the expected writes of a frame into a queue on each start;
// a monitor pops and compares on every out_we.
module tb_pixel_shift_sequencer;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int HB = 2;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        ls;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pixel_shift_sequencer_if sif();

  pixel_shift_sequencer #(
    .SENSOR_WIDTH (W),
    .SENSOR_HEIGHT(H),
    .HBLANK       (HB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sif(sif)
  );

  wr_t exp_q[$];
  int  wr_cyc[$];
  int  hits[8][4];
  int  checks = 0;
  int  errors = 0;
  int  n_wr = 0;
  int  frame_wr = 0;
  int  n_done = 0;
  int  busy_cycles = 0;
  int  ready_low = 0;
  int  cyc = 0;
  int  vmode = 0;  // 0 low, 1 held high, 2 toggle, 3 random

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  always @(posedge clk) cyc++;

  // Sensor valid driver.
  initial begin
    sif.sensor_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (vmode)
        0:       sif.sensor_valid = 1'b0;
        1:       sif.sensor_valid = 1'b1;
        2:       sif.sensor_valid = ~sif.sensor_valid;
        default: sif.sensor_valid = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (sif.out_we) begin
      wr_t act;
      wr_t e;
      n_wr++;
      frame_wr++;
      wr_cyc.push_back(cyc);
      act = '{x: sif.out_x, y: sif.out_y, ls: sif.line_start};
      if (sif.out_x < 8 && sif.out_y < 4) hits[sif.out_x][sif.out_y]++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual=(%0d,%0d) required=no write", act.x, act.y);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL write actual=(%0d,%0d,ls=%0d) required=(%0d,%0d,ls=%0d)",
                   act.x, act.y, act.ls, e.x, e.y, e.ls);
        end
      end
    end
    if (sif.frame_done) n_done++;
    if (sif.busy) busy_cycles++;
    if (sif.busy && !sif.sensor_ready) ready_low++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: phase-major, then rows, then columns of the sensor.
  task automatic push_frame();
    wr_t e;
    for (int p = 0; p < 4; p++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) begin
          e.x  = 11'(2 * x + (p % 2));
          e.y  = 11'(2 * y + (p / 2));
          e.ls = (x == 0);
          exp_q.push_back(e);
        end
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 4; j++) hits[i][j] = 0;
    frame_wr    = 0;
    busy_cycles = 0;
    ready_low   = 0;
    wr_cyc.delete();
  endtask

  task automatic launch();
    push_frame();
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int base);
    int b = 0;
    while (n_done == base && b < 1000) begin
      @(posedge clk);
      b++;
    end
    check(name, 64'(n_done), 64'(base + 1));
    @(negedge clk);
    check({name, "_busy_fall"}, 64'(sif.busy), 64'd0);
  endtask

  task automatic wait_writes(input string name, input int n);
    int b = 0;
    while (frame_wr < n && b < 1000) begin
      @(posedge clk);
      b++;
    end
    #1;
    check(name, 64'(frame_wr >= n), 64'd1);
  endtask

  task automatic check_cover(input string name);
    int once = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 4; j++) if (hits[i][j] == 1) once++;
    check(name, 64'(once), 64'd32);
    check({name, "_count"}, 64'(frame_wr), 64'd32);
    check({name, "_queue"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_idle_zero(input string name);
    check(name, 64'({sif.out_we, sif.out_x, sif.out_y, sif.phase, sif.line_start,
                     sif.sensor_ready, sif.busy, sif.frame_done}), 64'd0);
  endtask

  initial begin
    int base;
    int snap;
    sif.start = 1'b0;
    sif.abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset_state");

    // Start on the very first cycle out of reset, valid held high.
    @(posedge clk);
    #1;
    vmode = 1;
    push_frame();
    rst       = 1'b1;
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    base = n_done;
    wait_done("held_frame_done", base);
    check_cover("held_cover");
    check("held_busy_cycles", 64'(busy_cycles), 64'(4 * W * H + 4 * H * HB + 1));
    check("held_ready_low", 64'(ready_low), 64'(4 * H * HB + 1));
    if (wr_cyc.size() > 4) check("line_gap", 64'(wr_cyc[4] - wr_cyc[3]), 64'(HB + 1));
    else check("line_gap_writes", 64'(wr_cyc.size()), 64'd5);

    // Toggled valid, with start pulses while busy that must be ignored.
    vmode = 2;
    base  = n_done;
    launch();
    repeat (7) tick();
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    repeat (20) tick();
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    wait_done("toggle_frame_done", base);
    check_cover("toggle_cover");

    // start together with abort in IDLE.
    vmode     = 1;
    snap      = n_wr;
    sif.start = 1'b1;
    sif.abort = 1'b1;
    tick();
    sif.start = 1'b0;
    sif.abort = 1'b0;
    @(negedge clk);
    check("start_abort_idle_busy", 64'(sif.busy), 64'd0);
    repeat (5) tick();
    check("start_abort_idle_writes", 64'(n_wr), 64'(snap));

    // Abort in phase 2, line 1.
    base = n_done;
    launch();
    wait_writes("abort_reach", 22);
    sif.abort = 1'b1;
    tick();
    sif.abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_busy", 64'(sif.busy), 64'd0);
    check("abort_ready", 64'(sif.sensor_ready), 64'd0);
    check("abort_phase", 64'(sif.phase), 64'd0);
    snap = n_wr;
    repeat (10) tick();
    check("abort_no_done", 64'(n_done), 64'(base));
    check("abort_no_writes", 64'(n_wr), 64'(snap));

    // Restart after abort with random valid.
    vmode = 3;
    base  = n_done;
    launch();
    wait_done("restart_frame_done", base);
    check_cover("restart_cover");

    // Reset during HBLANK of phase 1.
    vmode = 1;
    base  = n_done;
    launch();
    wait_writes("reset_reach", 12);
    rst = 1'b0;
    tick();
    exp_q.delete();
    @(negedge clk);
    check_idle_zero("midframe_reset");
    snap = n_wr;
    repeat (4) tick();
    check("reset_no_done", 64'(n_done), 64'(base));
    check("reset_no_writes", 64'(n_wr), 64'(snap));
    rst   = 1'b1;
    vmode = 3;
    tick();
    base = n_done;
    launch();
    wait_done("post_reset_frame_done", base);
    check_cover("post_reset_cover");

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pixel_shift_sequencer.md
PIXEL_SHIFT_SEQUENCER -- requirements
Module: pixel_shift_sequencer

Interface
REQ-001 SHALL have parameter SENSOR_WIDTH, default 960, sensor pixels per line.
REQ-002 SHALL have parameter SENSOR_HEIGHT, default 540, sensor lines per phase.
REQ-003 SHALL have parameter HBLANK, default 16, idle cycles between lines (legal range 1..255).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a 4-phase frame.
REQ-007 SHALL have port abort  input  1  terminate the frame in progress.
REQ-008 SHALL have port sensor_valid  input  1  sensor sample available.
REQ-009 SHALL have port sensor_ready  output  1  sequencer accepts a sample this cycle.
REQ-010 SHALL have port out_we  output  1  write strobe to the 1920x1080 luminance store.
REQ-011 SHALL have port out_x  output  11  output column of the current write.
REQ-012 SHALL have port out_y  output  11  output row of the current write.
REQ-013 SHALL have port phase  output  2  current shift phase (bit0 = horizontal half-pixel, bit1 = vertical).
REQ-014 SHALL have port line_start  output  1  one-cycle pulse on the first accepted sample of each line.
REQ-015 SHALL have port busy  output  1  high from ACTIVE entry until return to IDLE.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse when all four phases have completed.

Function
REQ-017 SHALL implement the states IDLE, ACTIVE, HBLANK and DONE.
REQ-018 IDLE: start=1 SHALL go to ACTIVE next cycle, with phase=0 and sensor counters sx=sy=0.
REQ-019 ACTIVE SHALL drive sensor_ready=1; every other state SHALL drive sensor_ready=0.
REQ-020 Handshake: a sample SHALL be accepted only in a cycle where sensor_valid=1 and sensor_ready=1; sensor_valid=0 stalls with all counters held and no timeout.
REQ-021 Each accepted sample SHALL produce exactly one out_we pulse one cycle later, with out_x=2*sx+phase[0] and out_y=2*sy+phase[1] computed from the values at acceptance (registered, 11-bit, no overflow for default parameters).
REQ-022 After an acceptance with sx<SENSOR_WIDTH-1, sx SHALL increment.
REQ-023 After an acceptance with sx=SENSOR_WIDTH-1, sx SHALL wrap to 0 and the FSM SHALL enter HBLANK.
REQ-024 HBLANK SHALL last exactly HBLANK cycles, counted by an 8-bit counter, and then exit.
REQ-025 On HBLANK exit with sy<SENSOR_HEIGHT-1: sy SHALL increment and the FSM SHALL return to ACTIVE.
REQ-026 On HBLANK exit with sy=SENSOR_HEIGHT-1 and phase<3: sy SHALL clear, phase SHALL increment (order 0,1,2,3) and the FSM SHALL return to ACTIVE.
REQ-027 On HBLANK exit with sy=SENSOR_HEIGHT-1 and phase=3: the FSM SHALL enter DONE.
REQ-028 DONE SHALL last one cycle with frame_done=1, then return to IDLE with phase=0.
REQ-029 line_start SHALL be registered alongside out_we and SHALL be high for the write produced by the sx=0 acceptance.
REQ-030 start SHALL be ignored outside IDLE.
REQ-031 abort=1 in any non-IDLE state SHALL force IDLE next cycle and clear counters and phase.
REQ-032 After an abort, frame_done SHALL NOT pulse and no out_we SHALL be issued, except a write already registered in the abort cycle itself.
REQ-033 abort and start asserted together in IDLE: abort SHALL take priority and the FSM SHALL stay in IDLE.
REQ-034 busy SHALL be 1 in ACTIVE, HBLANK and DONE, and 0 in IDLE.
REQ-035 Total out_we pulses per completed frame SHALL be 4*SENSOR_WIDTH*SENSOR_HEIGHT, and each output coordinate SHALL be written exactly once.

Reset
REQ-036 rst=0 sampled at a clk edge SHALL force IDLE and set sx, sy, phase, the blank counter, out_x, out_y, out_we, line_start, sensor_ready, busy and frame_done to 0.
REQ-037 Reset mid-frame SHALL behave as REQ-036, with no frame_done pulse and no further out_we.
REQ-038 The first start SHALL be honoured on the first cycle with rst=1.

Verification (SENSOR_WIDTH=4, SENSOR_HEIGHT=2, HBLANK=2 unless stated)
REQ-039 Start pulse, sensor_valid held 1 -> 32 out_we pulses covering every (x 0..7, y 0..3) exactly once; frame_done pulses once; busy then falls.
REQ-040 First phase -> sequence (0,0),(2,0),(4,0),(6,0) then exactly 2 cycles with sensor_ready=0, then (0,2); line_start high on (0,0) and (0,2).
REQ-041 sensor_valid toggled 1,0,1,0 -> out_we only on accepted cycles; coordinates identical to REQ-040; no sample dropped or duplicated.
REQ-042 abort asserted during phase 2, line 1 -> next cycle busy=0 and sensor_ready=0, no frame_done; a later start restarts at phase 0 with out (0,0).
REQ-043 rst=0 asserted during HBLANK of phase 1 -> all outputs 0 next cycle; start with rst=1 then runs a full 32-write frame.
REQ-044 start pulsed while busy, and start together with abort in IDLE -> both ignored, with no change to frame count or coordinates.
